id_ex_stage_reg: RTL and testbench
==================================

// Module: id_ex_stage_reg
// PURPOSE
//  ID/EX pipeline register with load-use hazard detection and bubble insertion.
//  Captures decoded operands/control from ID and presents them to EX.
//  Its outputs feed the EX-stage forwarding logic: rs_ex/rt_ex compared against EX/MEM and MEM/WB dests.
//  Generates stall controls back to PC and IF/ID; accepts branch flush and EX-busy hold.
// PARAMETERS
//  DW        32  datapath width (register data, immediate)
//  ALUOP_W   4   ALU opcode width
//  CNT_W     16  stall/bubble performance counter width (saturating)
// PORTS
//  clk           in   1        rising-edge clock
//  rst           in   1        synchronous reset, active-high
//  valid_id      in   1        ID holds a real instruction
//  rs_id/rt_id/rd_id in 5 each source/target/dest register numbers from ID
//  rd_sel_id     in   1        1: dest is rd, 0: dest is rt
//  uses_rt_id    in   1        instruction reads rt as a source
//  regwrite_id, memread_id, memwrite_id, memtoreg_id, alusrc_id  in 1 each  decoded control
//  aluop_id      in   ALUOP_W  ALU operation
//  rdata1_id, rdata2_id, imm_id  in DW each  register-file reads, sign-extended immediate
//  flush_ex      in   1        branch/jump resolved taken in EX; kill instruction in ID
//  ex_busy       in   1        multi-cycle EX op in progress; freeze pipeline front
//  *_ex          out  same     registered copies of every *_id field above, plus valid_ex
//  pc_write      out  1        0 = hold PC this cycle
//  ifid_write    out  1        0 = hold IF/ID this cycle
//  stall_cnt     out  CNT_W    cycles in which a load-use bubble was inserted
// BEHAVIOUR
//  Reset: all *_ex outputs 0 (bubble: valid_ex=0, regwrite_ex=0, memread_ex=0, memwrite_ex=0); stall_cnt=0.
//  ex_dest = rd_sel_ex ? rd_ex : rt_ex (combinational, from registered state).
//  load_use = memread_ex & valid_ex & valid_id & (ex_dest != 0) &
//             ((ex_dest == rs_id) | (uses_rt_id & ex_dest == rt_id)).
//  Per-edge update priority (highest first):
//   1. rst          -> reset values above.
//   2. flush_ex     -> load bubble (all control/valid 0, data fields 0); flush beats busy and load_use.
//   3. ex_busy      -> hold all *_ex registers unchanged.
//   4. load_use     -> load bubble; stall_cnt += 1 (saturates at all-ones, no wrap).
//   5. otherwise    -> capture all *_id fields; valid_ex = valid_id.
//  Combinational outputs (same cycle, from current state and inputs):
//   pc_write = ifid_write = ~(ex_busy | (load_use & ~flush_ex)).
//   flush_ex high: pc_write=1, ifid_write=1 (front end redirects; IF/ID flush is handled by IF/ID).
//  Latency: 1 cycle ID->EX. A load-use stalls exactly one cycle: next cycle the load is in MEM,
//   load_use deasserts, dependent instruction enters EX and receives MEM/WB forwarding.
//  Bubble never asserts regwrite/memread/memwrite, so forwarding ignores it.
//  Register 0 is never a hazard source. valid_id=0 never stalls.
//  ex_busy with load_use simultaneously: hold (no bubble, no count); load_use re-evaluated when busy drops.
//  rst mid-stall: reset wins; pc_write/ifid_write return to 1 next cycle.
// STRUCTURE
//  Shared package/header: ALUOP_W, ALU opcode constants, REG_ZERO=5'd0, bubble control constant.
//  Sub-module: hazard_detect (pure combinational load_use/pc_write/ifid_write); register bank in this module.
// TESTING
//  1. lw $5 in EX (memread_ex=1, rt_ex=5, rd_sel_ex=0), ID add rs=5 -> pc_write=0, ifid_write=0,
//     next edge valid_ex=0, regwrite_ex=0, stall_cnt=1; following edge captures add.
//  2. lw to $0, ID uses rs=0 -> no stall, pc_write=1, add captured next edge.
//  3. load_use and flush_ex same cycle -> bubble inserted, pc_write=1, stall_cnt unchanged.
//  4. ex_busy=1 for 3 cycles with new ID values -> *_ex constant, pc_write=0; capture on busy drop.
//  5. Force stall_cnt to 16'hFFFF, trigger load_use -> stays 16'hFFFF.
//  6. rst asserted during a stall cycle -> next edge all *_ex=0, stall_cnt=0, pc_write=1.

Source files
------------

// File: rtl/id_ex_stage_reg_pkg.sv
// Shared types and constants for the ID/EX stage register and its hazard logic.
// Register indices, ALU opcodes, control bundle and the all-zero bubble.
package id_ex_stage_reg_pkg;

    localparam int REG_W   = 5;
    localparam int ALUOP_W = 4;

    typedef logic [REG_W-1:0] reg_idx_t;

    localparam reg_idx_t REG_ZERO = 5'd0;

    localparam logic [ALUOP_W-1:0] ALU_ADD = 4'h0;
    localparam logic [ALUOP_W-1:0] ALU_SUB = 4'h1;
    localparam logic [ALUOP_W-1:0] ALU_AND = 4'h2;
    localparam logic [ALUOP_W-1:0] ALU_OR  = 4'h3;
    localparam logic [ALUOP_W-1:0] ALU_XOR = 4'h4;
    localparam logic [ALUOP_W-1:0] ALU_NOR = 4'h5;
    localparam logic [ALUOP_W-1:0] ALU_SLT = 4'h6;
    localparam logic [ALUOP_W-1:0] ALU_SLL = 4'h7;
    localparam logic [ALUOP_W-1:0] ALU_SRL = 4'h8;
    localparam logic [ALUOP_W-1:0] ALU_SRA = 4'h9;
    localparam logic [ALUOP_W-1:0] ALU_LUI = 4'hA;

    // Decoded control that travels with an instruction; valid rides along so a
    // bubble is a single all-zero constant.
    typedef struct packed {
        logic valid;
        logic regwrite;
        logic memread;
        logic memwrite;
        logic memtoreg;
        logic alusrc;
        logic rd_sel;
        logic uses_rt;
    } ctrl_t;

    localparam ctrl_t CTRL_BUBBLE = '0;

    function automatic reg_idx_t dest_reg(input logic rd_sel, input reg_idx_t rt, input reg_idx_t rd);
        return rd_sel ? rd : rt;
    endfunction

endpackage

// File: rtl/id_ex_stage_reg_hazard_detect.sv
// Load-use hazard detection and front-end write enables; purely combinational, 0 cycles.
// Backpressure: drops pc_write/ifid_write while EX is busy or a load-use bubble is being inserted.
module hazard_detect
    import id_ex_stage_reg_pkg::*;
(
    input  logic             valid_ex,
    input  logic             memread_ex,
    input  logic             rd_sel_ex,
    input  logic [REG_W-1:0] rt_ex,
    input  logic [REG_W-1:0] rd_ex,
    input  logic             valid_id,
    input  logic [REG_W-1:0] rs_id,
    input  logic [REG_W-1:0] rt_id,
    input  logic             uses_rt_id,
    input  logic             flush_ex,
    input  logic             ex_busy,
    output logic             load_use,
    output logic             pc_write,
    output logic             ifid_write
);

    reg_idx_t ex_dest;
    logic     rs_hit;
    logic     rt_hit;
    logic     front_hold;

    always_comb begin
        ex_dest = dest_reg(rd_sel_ex, rt_ex, rd_ex);
        rs_hit  = (ex_dest == rs_id);
        rt_hit  = uses_rt_id && (ex_dest == rt_id);
        // $0 is hard-wired, so a load targeting it never produces a dependency.
        load_use = memread_ex && valid_ex && valid_id && (ex_dest != REG_ZERO) && (rs_hit || rt_hit);
        // A taken branch redirects the front end, so a killed dependent must not hold it.
        front_hold = ex_busy || (load_use && !flush_ex);
        pc_write   = !front_hold;
        ifid_write = !front_hold;
    end

endmodule

// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline register with load-use bubble insertion and a saturating stall counter.
// Latency 1 cycle ID->EX; ex_busy freezes the register, a load-use inserts one bubble.
module id_ex_stage_reg
    import id_ex_stage_reg_pkg::*;
#(
    parameter int DW      = 32,
    parameter int ALUOP_W = id_ex_stage_reg_pkg::ALUOP_W,
    parameter int CNT_W   = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               valid_id,
    input  logic [REG_W-1:0]   rs_id,
    input  logic [REG_W-1:0]   rt_id,
    input  logic [REG_W-1:0]   rd_id,
    input  logic               rd_sel_id,
    input  logic               uses_rt_id,
    input  logic               regwrite_id,
    input  logic               memread_id,
    input  logic               memwrite_id,
    input  logic               memtoreg_id,
    input  logic               alusrc_id,
    input  logic [ALUOP_W-1:0] aluop_id,
    input  logic [DW-1:0]      rdata1_id,
    input  logic [DW-1:0]      rdata2_id,
    input  logic [DW-1:0]      imm_id,
    input  logic               flush_ex,
    input  logic               ex_busy,
    output logic               valid_ex,
    output logic [REG_W-1:0]   rs_ex,
    output logic [REG_W-1:0]   rt_ex,
    output logic [REG_W-1:0]   rd_ex,
    output logic               rd_sel_ex,
    output logic               uses_rt_ex,
    output logic               regwrite_ex,
    output logic               memread_ex,
    output logic               memwrite_ex,
    output logic               memtoreg_ex,
    output logic               alusrc_ex,
    output logic [ALUOP_W-1:0] aluop_ex,
    output logic [DW-1:0]      rdata1_ex,
    output logic [DW-1:0]      rdata2_ex,
    output logic [DW-1:0]      imm_ex,
    output logic               pc_write,
    output logic               ifid_write,
    output logic [CNT_W-1:0]   stall_cnt
);

    typedef struct packed {
        ctrl_t              ctrl;
        reg_idx_t           rs;
        reg_idx_t           rt;
        reg_idx_t           rd;
        logic [ALUOP_W-1:0] aluop;
        logic [DW-1:0]      rdata1;
        logic [DW-1:0]      rdata2;
        logic [DW-1:0]      imm;
    } ex_reg_t;

    ex_reg_t ex_q;
    ex_reg_t ex_d;
    logic    load_use;
    logic    bubble;
    logic    capture;
    logic    count_stall;

    hazard_detect u_hazard_detect (
        .valid_ex   (ex_q.ctrl.valid),
        .memread_ex (ex_q.ctrl.memread),
        .rd_sel_ex  (ex_q.ctrl.rd_sel),
        .rt_ex      (ex_q.rt),
        .rd_ex      (ex_q.rd),
        .valid_id   (valid_id),
        .rs_id      (rs_id),
        .rt_id      (rt_id),
        .uses_rt_id (uses_rt_id),
        .flush_ex   (flush_ex),
        .ex_busy    (ex_busy),
        .load_use   (load_use),
        .pc_write   (pc_write),
        .ifid_write (ifid_write)
    );

    always_comb begin
        ex_d.ctrl.valid    = valid_id;
        ex_d.ctrl.regwrite = regwrite_id;
        ex_d.ctrl.memread  = memread_id;
        ex_d.ctrl.memwrite = memwrite_id;
        ex_d.ctrl.memtoreg = memtoreg_id;
        ex_d.ctrl.alusrc   = alusrc_id;
        ex_d.ctrl.rd_sel   = rd_sel_id;
        ex_d.ctrl.uses_rt  = uses_rt_id;
        ex_d.rs            = rs_id;
        ex_d.rt            = rt_id;
        ex_d.rd            = rd_id;
        ex_d.aluop         = aluop_id;
        ex_d.rdata1        = rdata1_id;
        ex_d.rdata2        = rdata2_id;
        ex_d.imm           = imm_id;
    end

    // Flush outranks busy, busy outranks load-use: a held load is re-checked once busy drops.
    always_comb begin
        bubble      = flush_ex || (!ex_busy && load_use);
        capture     = !flush_ex && !ex_busy && !load_use;
        count_stall = !flush_ex && !ex_busy && load_use;
    end

    always_ff @(posedge clk) begin
        if (rst || bubble) begin
            ex_q      <= '0;
            ex_q.ctrl <= CTRL_BUBBLE;
        end else if (capture) begin
            ex_q <= ex_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (count_stall && (stall_cnt != {CNT_W{1'b1}})) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end

    assign valid_ex    = ex_q.ctrl.valid;
    assign regwrite_ex = ex_q.ctrl.regwrite;
    assign memread_ex  = ex_q.ctrl.memread;
    assign memwrite_ex = ex_q.ctrl.memwrite;
    assign memtoreg_ex = ex_q.ctrl.memtoreg;
    assign alusrc_ex   = ex_q.ctrl.alusrc;
    assign rd_sel_ex   = ex_q.ctrl.rd_sel;
    assign uses_rt_ex  = ex_q.ctrl.uses_rt;
    assign rs_ex       = ex_q.rs;
    assign rt_ex       = ex_q.rt;
    assign rd_ex       = ex_q.rd;
    assign aluop_ex    = ex_q.aluop;
    assign rdata1_ex   = ex_q.rdata1;
    assign rdata2_ex   = ex_q.rdata2;
    assign imm_ex      = ex_q.imm;

endmodule

// File: tb/tb_id_ex_stage_reg.sv
// Directed and random checks of id_ex_stage_reg against a behavioural pipeline-slot model.
// A narrow counter width keeps the saturation case reachable in a short run.
module tb_id_ex_stage_reg;

    localparam int DW    = 32;
    localparam int AW    = 4;
    localparam int CW    = 4;
    localparam int CMAX  = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          valid_id;
    logic [4:0]    rs_id, rt_id, rd_id;
    logic          rd_sel_id, uses_rt_id;
    logic          regwrite_id, memread_id, memwrite_id, memtoreg_id, alusrc_id;
    logic [AW-1:0] aluop_id;
    logic [DW-1:0] rdata1_id, rdata2_id, imm_id;
    logic          flush_ex, ex_busy;
    logic          valid_ex;
    logic [4:0]    rs_ex, rt_ex, rd_ex;
    logic          rd_sel_ex, uses_rt_ex;
    logic          regwrite_ex, memread_ex, memwrite_ex, memtoreg_ex, alusrc_ex;
    logic [AW-1:0] aluop_ex;
    logic [DW-1:0] rdata1_ex, rdata2_ex, imm_ex;
    logic          pc_write, ifid_write;
    logic [CW-1:0] stall_cnt;

    always #5 clk = ~clk;

    id_ex_stage_reg #(.DW(DW), .ALUOP_W(AW), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .valid_id(valid_id),
        .rs_id(rs_id), .rt_id(rt_id), .rd_id(rd_id),
        .rd_sel_id(rd_sel_id), .uses_rt_id(uses_rt_id),
        .regwrite_id(regwrite_id), .memread_id(memread_id), .memwrite_id(memwrite_id),
        .memtoreg_id(memtoreg_id), .alusrc_id(alusrc_id), .aluop_id(aluop_id),
        .rdata1_id(rdata1_id), .rdata2_id(rdata2_id), .imm_id(imm_id),
        .flush_ex(flush_ex), .ex_busy(ex_busy),
        .valid_ex(valid_ex), .rs_ex(rs_ex), .rt_ex(rt_ex), .rd_ex(rd_ex),
        .rd_sel_ex(rd_sel_ex), .uses_rt_ex(uses_rt_ex),
        .regwrite_ex(regwrite_ex), .memread_ex(memread_ex), .memwrite_ex(memwrite_ex),
        .memtoreg_ex(memtoreg_ex), .alusrc_ex(alusrc_ex), .aluop_ex(aluop_ex),
        .rdata1_ex(rdata1_ex), .rdata2_ex(rdata2_ex), .imm_ex(imm_ex),
        .pc_write(pc_write), .ifid_write(ifid_write), .stall_cnt(stall_cnt)
    );

    // Model of what instruction occupies the EX slot; an empty slot is all zeros.
    typedef struct {
        bit          valid, regwrite, memread, memwrite, memtoreg, alusrc, rd_sel, uses_rt;
        bit [4:0]    rs, rt, rd;
        bit [AW-1:0] aluop;
        bit [DW-1:0] r1, r2, imm;
    } slot_t;

    slot_t slot, empty_slot;
    int    m_cnt;
    bit    m_known = 0;
    bit    m_stall;
    int    n_checks = 0;
    int    n_fails  = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit model_load_use();
        int dest;
        dest = slot.rd_sel ? int'(slot.rd) : int'(slot.rt);
        if (!(slot.memread && slot.valid && valid_id)) return 0;
        if (dest == 0) return 0;
        return (dest == int'(rs_id)) || (uses_rt_id && dest == int'(rt_id));
    endfunction

    task automatic rand_id();
        valid_id    = ($urandom_range(0, 3) != 0);
        rs_id       = 5'($urandom_range(0, 3));
        rt_id       = 5'($urandom_range(0, 3));
        rd_id       = 5'($urandom_range(0, 3));
        rd_sel_id   = 1'($urandom);
        uses_rt_id  = 1'($urandom);
        regwrite_id = 1'($urandom);
        memread_id  = 1'($urandom);
        memwrite_id = 1'($urandom);
        memtoreg_id = 1'($urandom);
        alusrc_id   = 1'($urandom);
        aluop_id    = AW'($urandom);
        rdata1_id   = $urandom;
        rdata2_id   = $urandom;
        imm_id      = $urandom;
    endtask

    task automatic compare_state(input string tag);
        chk({tag, "_valid"}, 64'(valid_ex), 64'(slot.valid));
        chk({tag, "_ctrl"}, 64'({regwrite_ex, memread_ex, memwrite_ex, memtoreg_ex, alusrc_ex, rd_sel_ex, uses_rt_ex}),
            64'({slot.regwrite, slot.memread, slot.memwrite, slot.memtoreg, slot.alusrc, slot.rd_sel, slot.uses_rt}));
        chk({tag, "_regs"}, 64'({rs_ex, rt_ex, rd_ex, aluop_ex}), 64'({slot.rs, slot.rt, slot.rd, slot.aluop}));
        chk({tag, "_rdata"}, {rdata1_ex, rdata2_ex}, {slot.r1, slot.r2});
        chk({tag, "_imm"}, 64'(imm_ex), 64'(slot.imm));
        chk({tag, "_cnt"}, 64'(stall_cnt), 64'(m_cnt));
    endtask

    // Inputs are already applied; check front-end enables, clock once, check the new EX slot.
    task automatic step(input string tag);
        bit lu;
        #1;
        lu = m_known ? model_load_use() : 1'b0;
        m_stall = m_known && (ex_busy || (lu && !flush_ex));
        if (m_known) begin
            chk({tag, "_pcw"}, 64'(pc_write), 64'(!m_stall));
            chk({tag, "_ifidw"}, 64'(ifid_write), 64'(!m_stall));
        end
        if (rst) begin
            slot = empty_slot; m_cnt = 0; m_known = 1;
        end else if (flush_ex) begin
            slot = empty_slot;
        end else if (ex_busy) begin
            slot = slot;
        end else if (lu) begin
            slot = empty_slot;
            if (m_cnt < CMAX) m_cnt++;
        end else begin
            slot.valid = valid_id; slot.regwrite = regwrite_id; slot.memread = memread_id;
            slot.memwrite = memwrite_id; slot.memtoreg = memtoreg_id; slot.alusrc = alusrc_id;
            slot.rd_sel = rd_sel_id; slot.uses_rt = uses_rt_id;
            slot.rs = rs_id; slot.rt = rt_id; slot.rd = rd_id; slot.aluop = aluop_id;
            slot.r1 = rdata1_id; slot.r2 = rdata2_id; slot.imm = imm_id;
        end
        @(posedge clk);
        #1;
        if (m_known) compare_state(tag);
    endtask

    // Put a valid load writing rt=dst into the ID stage.
    task automatic load_to(input logic [4:0] dst);
        rand_id();
        valid_id = 1; memread_id = 1; rd_sel_id = 0; rt_id = dst;
        rst = 0; flush_ex = 0; ex_busy = 0;
    endtask

    // Put a valid non-load reading rs=src (rt unused) into the ID stage.
    task automatic user_of(input logic [4:0] src);
        rand_id();
        valid_id = 1; memread_id = 0; rs_id = src; uses_rt_id = 0;
        rst = 0; flush_ex = 0; ex_busy = 0;
    endtask

    initial begin
        empty_slot = '{default: 0};
        slot = empty_slot;
        m_cnt = 0;
        rand_id();
        rst = 1; flush_ex = 0; ex_busy = 0;
        step("reset0");
        step("reset1");
        chk("reset_pcw", 64'(pc_write), 64'(1));

        // 1: load-use on rs -> one bubble, counted, then the dependent enters EX
        load_to(5'd5); step("t1_load");
        user_of(5'd5); step("t1_stall");
        chk("t1_bubble_valid", 64'(valid_ex), 64'(0));
        chk("t1_cnt1", 64'(stall_cnt), 64'(1));
        step("t1_capture");
        chk("t1_add_valid", 64'(valid_ex), 64'(1));

        // 2: load to $0 never stalls
        load_to(5'd0); step("t2_load0");
        user_of(5'd0); step("t2_nostall");
        chk("t2_valid", 64'(valid_ex), 64'(1));

        // 3: flush in the load-use cycle -> bubble, front end free, no count
        load_to(5'd3); step("t3_load");
        user_of(5'd3); flush_ex = 1; step("t3_flush");
        chk("t3_cnt", 64'(stall_cnt), 64'(1));

        // 4: ex_busy for three cycles holds EX, then capture; also busy masking a load-use
        user_of(5'd2); step("t4_pre");
        for (int i = 0; i < 3; i++) begin
            rand_id(); ex_busy = 1; step("t4_busy");
        end
        rand_id(); ex_busy = 0; step("t4_release");
        load_to(5'd1); step("t4_load");
        user_of(5'd1); ex_busy = 1; step("t4_busy_lu");
        ex_busy = 0; step("t4_lu_after_busy");

        // 5: counter saturates at all-ones
        for (int i = 0; i < CMAX + 3; i++) begin
            load_to(5'd4); step("t5_load");
            user_of(5'd4); step("t5_stall");
        end
        chk("t5_sat", 64'(stall_cnt), 64'(CMAX));

        // 6: reset during a stall cycle wins
        load_to(5'd6); step("t6_load");
        user_of(5'd6); rst = 1; step("t6_rst");
        rst = 0; step("t6_after");

        // Random traffic with small register numbers so hazards are frequent
        for (int i = 0; i < 600; i++) begin
            rand_id();
            rst      = ($urandom_range(0, 60) == 0);
            flush_ex = ($urandom_range(0, 7) == 0);
            ex_busy  = ($urandom_range(0, 5) == 0);
            step("rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
